// File: rtl/ram_req_ctrl.sv
// Request controller for a synchronous-read RAM: registered RAM drive, 2-cycle read pipeline,
// 4-entry in-order response FIFO with credit flow control. Optional macro RAM_REQ_CTRL_CLEAR_EN adds a RAM clear after reset.
module ram_req_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;

`ifdef RAM_REQ_CTRL_CLEAR_EN
    typedef enum logic {INIT, RUN} state_t;
    localparam state_t RST_STATE = INIT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    logic [ADDR_W-1:0] clr_addr;
`else
    typedef enum logic {RUN} state_t;
    localparam state_t RST_STATE = RUN;
`endif

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [1:0]        tag;
    logic              accept, rd_accept, push, pop;
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fill;

    assign accept    = req_valid & req_ready;
    assign rd_accept = accept & ~req_we;
    assign push      = tag[1];
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_valid = (fill != CNT_W'(0));
    assign rsp_data  = fifo_mem[rd_ptr];

    // Next state and credit count: reads outstanding (in flight or buffered) minus pops.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (rd_accept && !pop)
            cnt_nx = cnt + CNT_W'(1);
        else if (pop && !rd_accept)
            cnt_nx = cnt - CNT_W'(1);
`ifdef RAM_REQ_CTRL_CLEAR_EN
        if (state == INIT && clr_addr == LAST_ADDR)
            state_nx = RUN;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RST_STATE;
            cnt       <= '0;
            tag       <= '0;
            req_ready <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            tag       <= {tag[0], rd_accept};
            req_ready <= (state_nx == RUN) && (cnt_nx < CNT_W'(DEPTH));
        end
    end

    // RAM drive: clear sweep during INIT, otherwise the accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end
`ifdef RAM_REQ_CTRL_CLEAR_EN
        else if (state == INIT) begin
            ram_we   <= 1'b1;
            ram_addr <= clr_addr;
            ram_data <= '0;
        end
`endif
        else if (accept) begin
            ram_we   <= req_we;
            ram_addr <= req_addr;
            ram_data <= req_wdata;
        end else begin
            ram_we   <= 1'b0;
        end
    end

`ifdef RAM_REQ_CTRL_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            if (state == INIT)
                clr_addr <= clr_addr + ADDR_W'(1);
            busy <= (state_nx != RUN);
        end
    end
`else
    assign busy = 1'b0;
`endif

    // Response FIFO; credit gating guarantees it never overflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < DEPTH; i++)
                fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= ram_q;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fill <= fill + CNT_W'(1);
                2'b01:   fill <= fill - CNT_W'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule
